ac_mac_sequencer: RTL and testbench

//  FSM that sequences the accumulator (AC) register and ALU through one dot product C = sum(A[i]*B[i]), i=0..len-1.

---
 rtl/ac_mac_sequencer.sv | 133 +++++++++++++
 tb/tb_ac_mac_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_mac_sequencer.sv
// Dot-product sequencer: drives AC, ALU and data memory through C = sum(A[i]*B[i]).
// One run clears AC, performs len read-read-MAC triples, then writes AC to c_addr.
module ac_mac_sequencer #(
    parameter int WORD_SIZE = 24,
    parameter int ADDR_W    = 16,
    parameter int LEN_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [LEN_W-1:0]     len,
    input  logic [ADDR_W-1:0]    a_base,
    input  logic [ADDR_W-1:0]    b_base,
    input  logic [ADDR_W-1:0]    a_stride,
    input  logic [ADDR_W-1:0]    b_stride,
    input  logic [ADDR_W-1:0]    c_addr,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_rd,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 mem_wr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] ac_q,
    output logic                 ac_write_en,
    output logic [WORD_SIZE-1:0] ac_din,
    output logic                 ac_alu_to_ac,
    output logic [1:0]           alu_op,
    output logic [WORD_SIZE-1:0] alu_a,
    output logic [WORD_SIZE-1:0] alu_b
);

    typedef enum logic [2:0] {
        IDLE, CLR, RD_A, RD_B, MAC, WB, DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [LEN_W-1:0]   cnt_reg;
    logic [ADDR_W-1:0]  a_ptr_reg, b_ptr_reg;
    logic [ADDR_W-1:0]  a_stride_reg, b_stride_reg;
    logic [ADDR_W-1:0]  c_addr_reg;
    logic [WORD_SIZE-1:0] alu_a_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            a_ptr_reg    <= '0;
            b_ptr_reg    <= '0;
            a_stride_reg <= '0;
            b_stride_reg <= '0;
            c_addr_reg   <= '0;
            alu_a_reg    <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (start) begin
                    cnt_reg      <= len;
                    a_ptr_reg    <= a_base;
                    b_ptr_reg    <= b_base;
                    a_stride_reg <= a_stride;
                    b_stride_reg <= b_stride;
                    c_addr_reg   <= c_addr;
                end
                // A element arrives the cycle after its read; hold it for the MAC
                RD_B: alu_a_reg <= mem_rdata;
                MAC: begin
                    a_ptr_reg <= a_ptr_reg + a_stride_reg;
                    b_ptr_reg <= b_ptr_reg + b_stride_reg;
                    cnt_reg   <= cnt_reg - LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign ac_din = '0;
    assign alu_a  = alu_a_reg;
    assign alu_b  = mem_rdata;

    always_comb begin
        state_next   = state_reg;
        busy         = 1'b1;
        done         = 1'b0;
        mem_addr     = '0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_wdata    = '0;
        ac_write_en  = 1'b0;
        ac_alu_to_ac = 1'b0;
        alu_op       = 2'b00;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = CLR;
            end
            CLR: begin
                ac_write_en = 1'b1;
                state_next  = (cnt_reg == '0) ? WB : RD_A;
            end
            RD_A: begin
                mem_addr   = a_ptr_reg;
                mem_rd     = 1'b1;
                state_next = RD_B;
            end
            RD_B: begin
                mem_addr   = b_ptr_reg;
                mem_rd     = 1'b1;
                state_next = MAC;
            end
            MAC: begin
                alu_op       = 2'b10;
                ac_alu_to_ac = 1'b1;
                state_next   = (cnt_reg == LEN_W'(1)) ? WB : RD_A;
            end
            WB: begin
                mem_addr   = c_addr_reg;
                mem_wr     = 1'b1;
                mem_wdata  = ac_q;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Abort still lets a WB-cycle write complete, but skips DONE
        if (abort && state_reg != IDLE) state_next = IDLE;
    end

endmodule

// File: tb/tb_ac_mac_sequencer.sv
// Bench for ac_mac_sequencer with a memory, AC and ALU model around it.
// Expected writebacks are queued at launch and compared against observed writes.
module tb_ac_mac_sequencer;
    localparam int WS = 24;
    localparam int AW = 16;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [LW-1:0] len = '0;
    logic [AW-1:0] a_base = '0, b_base = '0, a_stride = '0, b_stride = '0, c_addr = '0;
    logic busy, done, mem_rd, mem_wr, ac_write_en, ac_alu_to_ac;
    logic [AW-1:0] mem_addr;
    logic [WS-1:0] mem_wdata, ac_din, alu_a, alu_b;
    logic [1:0]    alu_op;
    logic [WS-1:0] mem_rdata = '0;
    logic [WS-1:0] ac_q = '0;

    ac_mac_sequencer #(.WORD_SIZE(WS), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
        .a_base(a_base), .b_base(b_base), .a_stride(a_stride), .b_stride(b_stride),
        .c_addr(c_addr), .busy(busy), .done(done), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .ac_q(ac_q), .ac_write_en(ac_write_en), .ac_din(ac_din),
        .ac_alu_to_ac(ac_alu_to_ac), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b)
    );

    always #5 clk = ~clk;

    logic [WS-1:0] mem [0:65535];

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (ac_write_en) ac_q <= ac_din;
        else if (ac_alu_to_ac && alu_op == 2'b10) ac_q <= ac_q + alu_a * alu_b;
    end

    logic [AW+WS-1:0] obs_q[$];
    logic [AW+WS-1:0] exp_q[$];
    logic [AW-1:0]    rd_q[$];
    int done_cnt = 0;

    always @(negedge clk) begin
        if (mem_wr) obs_q.push_back({mem_addr, mem_wdata});
        if (mem_rd) rd_q.push_back(mem_addr);
        if (done) done_cnt++;
    end

    int compared = 0;
    int mismatched = 0;

    function automatic logic [WS-1:0] dot(input int n, input logic [AW-1:0] ab, as,
                                          input logic [AW-1:0] bb, bs);
        logic [WS-1:0] acc = '0;
        logic [AW-1:0] pa = ab, pb = bb;
        for (int i = 0; i < n; i++) begin
            acc = acc + mem[pa] * mem[pb];
            pa = pa + as;
            pb = pb + bs;
        end
        return acc;
    endfunction

    task automatic run(input logic [LW-1:0] n, input logic [AW-1:0] ab, as, bb, bs, ca,
                       output int lat);
        exp_q.push_back({ca, dot(int'(n), ab, as, bb, bs)});
        @(negedge clk);
        len = n; a_base = ab; a_stride = as; b_base = bb; b_stride = bs; c_addr = ca;
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 1000; k++) begin
            if (done) begin lat = k; break; end
            @(posedge clk); @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        compared++;
        if ({busy, done, mem_rd, mem_wr, ac_write_en, ac_alu_to_ac, mem_addr, mem_wdata, alu_a, alu_op} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got busy=%b done=%b rd=%b wr=%b addr=%h alu_a=%h op=%b required all zero",
                     busy, done, mem_rd, mem_wr, mem_addr, alu_a, alu_op);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++; $display("FAIL idle_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_basic_dot;
        int lat, ob0;
        logic [AW+WS-1:0] e, g;
        ob0 = obs_q.size();
        run(8'd3, 16'h0010, 16'h0001, 16'h0020, 16'h0001, 16'h0030, lat);
        e = exp_q.pop_front();
        g = (obs_q.size() > ob0) ? obs_q[ob0] : 'x;
        compared++;
        if (obs_q.size() != ob0 + 1 || g !== e || e[WS-1:0] !== 24'd32) begin
            mismatched++; $display("FAIL t1_writeback: got %h required %h (32 at 0x30)", g, e);
        end
        compared++;
        if (lat != 12) begin
            mismatched++; $display("FAIL t1_latency: got %0d required 12", lat);
        end
    endtask

    task automatic test_len_zero;
        int lat, ob0, r0;
        logic [AW+WS-1:0] e, g;
        ob0 = obs_q.size(); r0 = rd_q.size();
        run(8'd0, 16'h0010, 16'h0001, 16'h0020, 16'h0001, 16'h0031, lat);
        e = exp_q.pop_front();
        g = (obs_q.size() > ob0) ? obs_q[ob0] : 'x;
        compared++;
        if (obs_q.size() != ob0 + 1 || g !== {16'h0031, 24'd0} || g !== e) begin
            mismatched++; $display("FAIL t2_writeback: got %h required %h", g, {16'h0031, 24'd0});
        end
        compared++;
        if (lat != 3) begin
            mismatched++; $display("FAIL t2_latency: got %0d required 3", lat);
        end
        compared++;
        if (rd_q.size() != r0) begin
            mismatched++; $display("FAIL t2_no_reads: got %0d reads required 0", rd_q.size() - r0);
        end
    endtask

    task automatic test_wrap_overflow;
        int lat, ob0, r0;
        logic [AW+WS-1:0] e, g;
        ob0 = obs_q.size(); r0 = rd_q.size();
        run(8'd2, 16'hFFFF, 16'h0001, 16'h0100, 16'h0001, 16'h0110, lat);
        e = exp_q.pop_front();
        g = (obs_q.size() > ob0) ? obs_q[ob0] : 'x;
        compared++;
        if (obs_q.size() != ob0 + 1 || g !== e || e[WS-1:0] !== 24'h00000D) begin
            mismatched++; $display("FAIL t3_writeback: got %h required %h", g, e);
        end
        compared++;
        if (rd_q.size() != r0 + 4 || rd_q[r0] !== 16'hFFFF || rd_q[r0+1] !== 16'h0100 || rd_q[r0+2] !== 16'h0000) begin
            mismatched++;
            $display("FAIL t3_read_addrs: got %h %h %h required ffff 0100 0000",
                     rd_q[r0], rd_q[r0+1], rd_q[r0+2]);
        end
        compared++;
        if (lat != 9) begin
            mismatched++; $display("FAIL t3_latency: got %0d required 9", lat);
        end
    endtask

    task automatic test_back_to_back;
        int ob0, d0, lat;
        logic [AW+WS-1:0] e, g;
        ob0 = obs_q.size(); d0 = done_cnt;
        exp_q.push_back({16'h0060, dot(2, 16'h0010, 16'h0001, 16'h0020, 16'h0001)});
        @(negedge clk);
        len = 8'd2; a_base = 16'h0010; a_stride = 16'h0001;
        b_base = 16'h0020; b_stride = 16'h0001; c_addr = 16'h0060;
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            compared++;
            if (busy !== (k <= 9)) begin
                mismatched++; $display("FAIL t4_busy_cycle%0d: got %b required %b", k, busy, (k <= 9));
            end
            if (k == 10) start = 1'b0;
            @(posedge clk);
        end
        repeat (4) @(negedge clk);
        e = exp_q.pop_front();
        g = (obs_q.size() > ob0) ? obs_q[ob0] : 'x;
        compared++;
        if (obs_q.size() != ob0 + 1 || done_cnt != d0 + 1 || g !== e) begin
            mismatched++;
            $display("FAIL t4_single_run: got writes=%0d dones=%0d data=%h required 1 1 %h",
                     obs_q.size() - ob0, done_cnt - d0, g, e);
        end
        ob0 = obs_q.size();
        run(8'd1, 16'h0012, 16'h0001, 16'h0022, 16'h0001, 16'h0061, lat);
        e = exp_q.pop_front();
        g = (obs_q.size() > ob0) ? obs_q[ob0] : 'x;
        compared++;
        if (g !== e || e[WS-1:0] !== 24'd18 || lat != 6) begin
            mismatched++; $display("FAIL t4_restart: got %h lat %0d required %h lat 6", g, lat, e);
        end
    endtask

    task automatic test_abort;
        int ob0, d0;
        ob0 = obs_q.size(); d0 = done_cnt;
        @(negedge clk);
        len = 8'd4; a_base = 16'h0010; a_stride = 16'h0001;
        b_base = 16'h0020; b_stride = 16'h0001; c_addr = 16'h0070;
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (6) begin @(posedge clk); @(negedge clk); end
        compared++;
        if (alu_op !== 2'b10 || ac_alu_to_ac !== 1'b1) begin
            mismatched++; $display("FAIL t5_in_mac: got op=%b alu_to_ac=%b required 10 1", alu_op, ac_alu_to_ac);
        end
        abort = 1'b1;
        @(posedge clk); @(negedge clk);
        abort = 1'b0;
        compared++;
        if (busy !== 1'b0) begin
            mismatched++; $display("FAIL t5_abort_idle: got busy=%b required 0", busy);
        end
        repeat (15) @(negedge clk);
        compared++;
        if (obs_q.size() != ob0 || done_cnt != d0) begin
            mismatched++; $display("FAIL t5_no_wb: got writes=%0d dones=%0d required 0 0",
                                   obs_q.size() - ob0, done_cnt - d0);
        end
        // abort landing on WB: write still happens, done does not
        ob0 = obs_q.size(); d0 = done_cnt;
        @(negedge clk);
        len = 8'd0; c_addr = 16'h0071; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        compared++;
        if (mem_wr !== 1'b1) begin
            mismatched++; $display("FAIL t5_wb_reached: got mem_wr=%b required 1", mem_wr);
        end
        abort = 1'b1;
        @(posedge clk); @(negedge clk);
        abort = 1'b0;
        repeat (4) @(negedge clk);
        compared++;
        if (obs_q.size() != ob0 + 1 || done_cnt != d0 || busy !== 1'b0) begin
            mismatched++; $display("FAIL t5_wb_abort: got writes=%0d dones=%0d busy=%b required 1 0 0",
                                   obs_q.size() - ob0, done_cnt - d0, busy);
        end
    endtask

    task automatic test_reset_midrun;
        int lat, ob0;
        logic [AW+WS-1:0] e, g;
        @(negedge clk);
        len = 8'd3; a_base = 16'h0010; a_stride = 16'h0001;
        b_base = 16'h0020; b_stride = 16'h0001; c_addr = 16'h0080;
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        compared++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0020) begin
            mismatched++; $display("FAIL t6_in_rd_b: got rd=%b addr=%h required 1 0020", mem_rd, mem_addr);
        end
        #1 rst = 1'b1;
        #1;
        compared++;
        if ({busy, done, mem_rd, mem_wr, ac_write_en, ac_alu_to_ac, mem_addr, mem_wdata, alu_a, alu_op} !== '0) begin
            mismatched++; $display("FAIL t6_async_reset: got busy=%b rd=%b addr=%h alu_a=%h required all zero",
                                   busy, mem_rd, mem_addr, alu_a);
        end
        @(negedge clk);
        rst = 1'b0;
        ob0 = obs_q.size();
        run(8'd3, 16'h0010, 16'h0001, 16'h0020, 16'h0001, 16'h0030, lat);
        e = exp_q.pop_front();
        g = (obs_q.size() > ob0) ? obs_q[ob0] : 'x;
        compared++;
        if (g !== e || e[WS-1:0] !== 24'd32 || lat != 12) begin
            mismatched++; $display("FAIL t6_fresh_run: got %h lat %0d required %h lat 12", g, lat, e);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem[16'h0010] = 24'd1; mem[16'h0011] = 24'd2; mem[16'h0012] = 24'd3; mem[16'h0013] = 24'd7;
        mem[16'h0020] = 24'd4; mem[16'h0021] = 24'd5; mem[16'h0022] = 24'd6; mem[16'h0023] = 24'd8;
        mem[16'hFFFF] = 24'h7FFFFF; mem[16'h0000] = 24'd5;
        mem[16'h0100] = 24'd2;      mem[16'h0101] = 24'd3;
        test_reset;
        test_basic_dot;
        test_len_zero;
        test_wrap_overflow;
        test_back_to_back;
        test_abort;
        test_reset_midrun;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
